// File: rtl/sample_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_fifo_if : write/read/status bundle of the sample FIFO          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sample_fifo_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             clear_flags_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output flush_i, clear_flags_i, wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, clear_flags_i, wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_fifo : single-clock sample buffer, wrap-bit pointers, FWFT opt |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sample_fifo #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  sample_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sample_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("sample_fifo: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $error("sample_fifo: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_idx;
  logic             empty, full;
  logic             wr_acc, rd_acc, ovf_evt, udf_evt;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count  = wr_ptr_q - rd_ptr_q;
  assign rd_idx = rd_ptr_q[PTR_W-1:0];

  assign wr_acc  = bus.wr_en_i && !full  && !bus.flush_i;
  assign rd_acc  = bus.rd_en_i && !empty && !bus.flush_i;
  assign ovf_evt = bus.wr_en_i &&  full  && !bus.flush_i;
  assign udf_evt = bus.rd_en_i &&  empty && !bus.flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A new error event in the same cycle as a clear keeps the flag set.
    if (ovf_evt)                ovf_d = 1'b1;
    else if (bus.clear_flags_i) ovf_d = 1'b0;
    if (udf_evt)                udf_d = 1'b1;
    else if (bus.clear_flags_i) udf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.wr_data_i;
  end

  if (FWFT == 0) begin : g_reg_read
    logic [WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk) begin
      if (!rst_n)      rd_data_q <= '0;
      else if (rd_acc) rd_data_q <= mem_q[rd_idx];
    end
    assign bus.rd_data_o = rd_data_q;
  end else begin : g_fwft_read
    assign bus.rd_data_o = empty ? '0 : mem_q[rd_idx];
  end

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.count_o        = count;
  assign bus.almost_full_o  = (count >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty_o = (count <= CNT_W'(AE_LEVEL));
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;
endmodule
`default_nettype wire

// File: tb/tb_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sample_fifo : registered and FWFT instances against a queue model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sample_fifo;
  localparam int WIDTH = 24;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Reference model: a bounded queue plus the last popped word and flags.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf, m_udf;
  int               n_assert = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int          n;
    logic [31:0] fw_exp;
    n      = q.size();
    fw_exp = (n == 0) ? 32'd0 : 32'(q[0]);
    check("reg.count",   32'(bus0.count_o),        32'(n));
    check("reg.empty",   32'(bus0.empty_o),        32'(n == 0));
    check("reg.full",    32'(bus0.full_o),         32'(n == DEPTH));
    check("reg.afull",   32'(bus0.almost_full_o),  32'(n >= AF));
    check("reg.aempty",  32'(bus0.almost_empty_o), 32'(n <= AE));
    check("reg.ovf",     32'(bus0.overflow_o),     32'(m_ovf));
    check("reg.udf",     32'(bus0.underflow_o),    32'(m_udf));
    check("reg.rdata",   32'(bus0.rd_data_o),      32'(m_last));
    check("fwft.count",  32'(bus1.count_o),        32'(n));
    check("fwft.empty",  32'(bus1.empty_o),        32'(n == 0));
    check("fwft.full",   32'(bus1.full_o),         32'(n == DEPTH));
    check("fwft.ovf",    32'(bus1.overflow_o),     32'(m_ovf));
    check("fwft.udf",    32'(bus1.underflow_o),    32'(m_udf));
    check("fwft.rdata",  32'(bus1.rd_data_o),      fw_exp);
  endtask

  // One clock: drive both instances identically, advance the model, check.
  task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] d,
                      input logic rd, input logic fl, input logic cl);
    logic was_full, was_empty;
    rst_n = r;
    bus0.wr_en_i = w;  bus0.wr_data_i = d; bus0.rd_en_i = rd;
    bus0.flush_i = fl; bus0.clear_flags_i = cl;
    bus1.wr_en_i = w;  bus1.wr_data_i = d; bus1.rd_en_i = rd;
    bus1.flush_i = fl; bus1.clear_flags_i = cl;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_last = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (fl) begin
      q.delete();
      if (cl) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rd && !was_empty) m_last = q.pop_front();
      if (w && !was_full)   q.push_back(d);
      if (w && was_full)       m_ovf = 1'b1;
      else if (cl)             m_ovf = 1'b0;
      if (rd && was_empty)     m_udf = 1'b1;
      else if (cl)             m_udf = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic w, rd, fl, cl, r;
    m_last = '0; m_ovf = 1'b0; m_udf = 1'b0;

    // Reset, then idle.
    step(0, 0, '0, 0, 0, 0);
    step(0, 1, 24'h5A5A5A, 1, 0, 0);
    step(1, 0, '0, 0, 0, 0);

    // Fill to capacity, one extra write is dropped and sets overflow.
    for (int i = 1; i <= 16; i++) step(1, 1, 24'(i), 0, 0, 0);
    step(1, 1, 24'hAAAAAA, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 0, 0, 1);

    // FWFT visibility, pop to empty, underflow, clear.
    step(1, 1, 24'h123456, 0, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 0, 0, 1);

    // Wrap-around with simultaneous traffic at count 8.
    for (int i = 0; i < 8; i++) step(1, 1, 24'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 24'($urandom), 1, 0, 0);

    // Boundary simultaneity at full and at empty.
    for (int i = 0; i < 8; i++) step(1, 1, 24'($urandom), 0, 0, 0);
    step(1, 1, 24'hBEEF01, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 0, 0, 1);
    step(1, 1, 24'hC0FFEE, 1, 0, 0);

    // Flush at count 5 alongside a write; flags survive.
    for (int i = 0; i < 4; i++) step(1, 1, 24'($urandom), 0, 0, 0);
    step(1, 1, 24'h777777, 0, 1, 0);
    step(1, 1, 24'h010203, 0, 0, 0);

    // Randomised traffic with occasional flush, clear and reset.
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 3);
      cl = ($urandom_range(0, 99) < 5);
      r  = ($urandom_range(0, 199) != 0);
      d  = 24'($urandom);
      step(r, w, d, rd, fl, cl);
    end

    // Reset mid-burst.
    for (int i = 0; i < 6; i++) step(1, 1, 24'($urandom), i[0], 0, 0);
    step(0, 1, 24'h999999, 1, 0, 0);
    step(1, 0, '0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
